dac_tlv5638_seq: RTL and testbench
==================================

# dac_tlv5638_seq

Dual-channel command sequencer that sits directly upstream of the TLV5638 serial DAC driver and produces its 16-bit `config_reg` command word. It accepts (A, B) 12-bit sample pairs over a valid/ready handshake and turns each pair into a two-frame command sequence. The sequence writes B to the DAC buffer, then writes A with a simultaneous update of B, so both outputs change together. It also issues the reference/speed control word after reset and on request, and tracks the driver's 1 MSPS frame rate via its `irq` output.

## Interface
- `REF_SEL`, default 2'b10: TLV5638 reference select written to control register (00 ext, 01 1.024 V, 10 2.048 V).
- `SPD`, default 1'b1: speed bit placed in every word (1 = fast).
- `clk_20M`  in  1: system clock, same clock as the DAC driver.
- `rst`  in  1: reset, synchronous, active-high.
- `irq`  in  1: frame tick from the DAC driver (1 MHz, 50 % duty); rising edge marks a slot boundary.
- `s_valid`  in  1: sample pair valid.
- `s_ready`  out  1: sample pair accepted when `s_valid & s_ready`.
- `s_data_a`  in  12: channel A code.
- `s_data_b`  in  12: channel B code.
- `ref_update`  in  1: single-cycle request to re-send the control word.
- `config_reg`  out  16: command word consumed by the DAC driver.
- `pair_done`  out  1: one-cycle pulse when the A/update word of a pair is issued.
- `underrun`  out  1: one-cycle pulse when a pair slot starts with no data available.

## Operation
- Word formats, with bit 15 = R1, bit 14 = SPD, bit 13 = PWR = 0, bit 12 = R0:
  - CTRL = {1, SPD, 0, 1, 10'b0, REF_SEL}.
  - BUF_B = {0, SPD, 0, 1, b}.
  - WR_A = {1, SPD, 0, 0, a}.
- Storage:
  - `hold` register: one pair plus full flag.
  - `act_a` register: 12 bits, the A code of the pair in flight.
  - `ctrl_pend` flag.
- `s_ready = !hold_full`, combinational.
- Acceptance:
  - A handshake loads `hold`.
  - A handshake and a hold-drain in the same cycle is legal. The new pair loads and full stays set.
- `ctrl_pend`: set by `ref_update`, cleared when CTRL is issued.
- States: IDLE, PAIR_A.
  - IDLE, on slot edge:
    1. If `ctrl_pend`: issue CTRL and stay in IDLE.
    2. Else if `hold_full`: issue BUF_B(hold.b), copy hold.a to `act_a`, clear `hold_full`, and go to PAIR_A.
    3. Else: repeat the current `config_reg` unchanged and pulse `underrun`. Repeating the last word is harmless (it rewrites the same A and B values).
  - PAIR_A, on slot edge: issue WR_A(act_a), pulse `pair_done`, return to IDLE. A pending CTRL waits. It is never inserted between BUF_B and WR_A.
- Only one `underrun` pulse is issued per starved slot edge. No underrun is reported before the first pair is ever accepted (flag `started`).
- Throughput: one pair per two frames, i.e. 500 k pairs/s.

## Timing
- Slot edge: `irq & !irq_d`, where `irq_d` is a registered copy of `irq` (reset value 1, so there is no spurious edge out of reset).
- `config_reg`, `pair_done` and `underrun` update on the clock after the edge cycle (latency 1). Between updates `config_reg` is held stable. This guarantees the word is stable at the driver's latch point, which is ≥9 clocks from the `irq` rise.
- Reset values:
  - `config_reg` = CTRL, so the first frames program the reference.
  - `pair_done` = 0, `underrun` = 0.
  - `hold_full` = 0, so `s_ready` = 1 once reset is deasserted.
  - `ctrl_pend` = 0, state IDLE, `started` = 0.
- Reset mid-pair (after BUF_B, before WR_A): the pair is dropped and `config_reg` returns to CTRL. The DAC B buffer is left stale until the next pair.
- `ref_update` coinciding with a slot edge in IDLE: the flag is set, but this edge is decided on the old flag. CTRL is issued at the next IDLE edge.

## Structure
- Package `dac_tlv5638_pkg` holds:
  - R1/R0 code constants (BUF = 2'b01, A_UPD = 2'b10, CTRL = 2'b11).
  - Reference-select constants.
  - A word-builder function (r1r0, spd, data12) -> 16 bits.
- No sub-module; the edge detector and the two-state FSM are inline.

## Test plan
1. Reset with REF_SEL = 2'b10, SPD = 1 -> `config_reg` = 16'hD002 and `s_ready` = 1; no `underrun` before the first pair.
2. Accept a = 12'h123, b = 12'hABC, then two `irq` edges -> `config_reg` = 16'h5ABC, then 16'hC123. `pair_done` pulses once, after the second edge.
3. Back-to-back pairs with `s_valid` held high -> `s_ready` drops for one cycle window only while `hold` is full. Words alternate B/A with no repeats and no `underrun`.
4. `ref_update` asserted during PAIR_A -> the WR_A word is issued first, then 16'hD002 on the next edge, then the next BUF_B.
5. Starve after one pair -> one `underrun` pulse per edge, and `config_reg` stays 16'hC123.
6. `rst` asserted between BUF_B and WR_A -> the next cycle shows 16'hD002, `hold_full` = 0, state IDLE, and no `pair_done`.

Source files
------------

// File: rtl/dac_tlv5638_seq_pkg.sv
// Shared constants and the command-word builder for the TLV5638 command sequencer.
package dac_tlv5638_pkg;

    // R1/R0 register-select codes (bit 15 = R1, bit 12 = R0)
    localparam logic [1:0] RR_BUF   = 2'b01;
    localparam logic [1:0] RR_A_UPD = 2'b10;
    localparam logic [1:0] RR_CTRL  = 2'b11;

    // Reference select values for the control register
    localparam logic [1:0] REF_EXT   = 2'b00;
    localparam logic [1:0] REF_1V024 = 2'b01;
    localparam logic [1:0] REF_2V048 = 2'b10;

    // Sequencer state; PAIR_A means BUF_B went out and WR_A is owed
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_PAIR_A = 1'b1
    } state_e;

    // Assemble {R1, SPD, PWR=0, R0, data12}
    function automatic logic [15:0] build_word(input logic [1:0] r1r0,
                                               input logic       spd,
                                               input logic [11:0] data12);
        return {r1r0[1], spd, 1'b0, r1r0[0], data12};
    endfunction

endpackage

// File: rtl/dac_tlv5638_seq_if.sv
// Sample-pair stream into the sequencer.
// Handshake: a pair transfers on every clock edge where s_valid && s_ready;
// the master holds s_data_a/s_data_b stable while s_valid is high and not yet
// accepted, and s_ready never depends on s_valid.
interface dac_tlv5638_seq_if;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_data_a;
    logic [11:0] s_data_b;

    modport master (output s_valid, output s_data_a, output s_data_b, input s_ready);
    modport slave  (input s_valid, input s_data_a, input s_data_b, output s_ready);
endinterface

// File: rtl/dac_tlv5638_seq.sv
// Dual-channel command sequencer feeding the TLV5638 driver's config_reg.
// Each (A, B) pair becomes BUF_B then WR_A on consecutive irq slot edges so
// both DAC outputs update together; the control word is sent after reset and
// whenever ref_update requests it.
module dac_tlv5638_seq
    import dac_tlv5638_pkg::*;
#(
    parameter logic [1:0] REF_SEL = REF_2V048,
    parameter logic       SPD     = 1'b1
) (
    input  logic                     clk_20M,
    input  logic                     rst,
    input  logic                     irq,
    dac_tlv5638_seq_if.slave         s_if,
    input  logic                     ref_update,
    output logic [15:0]              config_reg,
    output logic                     pair_done,
    output logic                     underrun,
    output state_e                   dbg_state
);

    localparam logic [15:0] CTRL_WORD = build_word(RR_CTRL, SPD, {10'b0, REF_SEL});

    state_e      state_q, state_d;
    logic        irq_d_q, irq_d_d;
    logic [11:0] hold_a_q, hold_a_d;
    logic [11:0] hold_b_q, hold_b_d;
    logic        hold_full_q, hold_full_d;
    logic [11:0] act_a_q, act_a_d;
    logic        ctrl_pend_q, ctrl_pend_d;
    logic        started_q, started_d;
    logic [15:0] config_q, config_d;
    logic        pair_done_q, pair_done_d;
    logic        underrun_q, underrun_d;

    logic        slot_edge;
    logic        accept;
    logic        drain;
    logic        issue_ctrl;

    assign slot_edge   = irq & ~irq_d_q;
    assign s_if.s_ready = ~hold_full_q;
    assign accept      = s_if.s_valid & ~hold_full_q;

    assign config_reg = config_q;
    assign pair_done  = pair_done_q;
    assign underrun   = underrun_q;
    assign dbg_state  = state_q;

    // Slot decision: pick the word for this edge and advance the two-state FSM
    always_comb begin
        state_d     = state_q;
        config_d    = config_q;
        act_a_d     = act_a_q;
        pair_done_d = 1'b0;
        underrun_d  = 1'b0;
        drain       = 1'b0;
        issue_ctrl  = 1'b0;
        if (slot_edge) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ctrl_pend_q) begin
                        config_d   = CTRL_WORD;
                        issue_ctrl = 1'b1;
                    end else if (hold_full_q) begin
                        config_d = build_word(RR_BUF, SPD, hold_b_q);
                        act_a_d  = hold_a_q;
                        drain    = 1'b1;
                        state_d  = ST_PAIR_A;
                    end else begin
                        // Starved slot: the last word is simply repeated
                        underrun_d = started_q;
                    end
                end
                ST_PAIR_A: begin
                    // A pending CTRL never splits a pair; it waits for IDLE
                    config_d    = build_word(RR_A_UPD, SPD, act_a_q);
                    pair_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Holding register, control-pending flag and edge-detector inputs
    always_comb begin
        irq_d_d     = irq;
        hold_a_d    = hold_a_q;
        hold_b_d    = hold_b_q;
        hold_full_d = hold_full_q;
        started_d   = started_q;
        ctrl_pend_d = ctrl_pend_q;
        // A request in the same cycle as issuing CTRL keeps the flag set
        if (issue_ctrl) ctrl_pend_d = 1'b0;
        if (ref_update) ctrl_pend_d = 1'b1;
        if (drain) hold_full_d = 1'b0;
        if (accept) begin
            hold_a_d    = s_if.s_data_a;
            hold_b_d    = s_if.s_data_b;
            hold_full_d = 1'b1;
            started_d   = 1'b1;
        end
    end

    // State register; reset drops any in-flight pair and restores CTRL
    always_ff @(posedge clk_20M) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            irq_d_q     <= 1'b1;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            hold_full_q <= 1'b0;
            act_a_q     <= '0;
            ctrl_pend_q <= 1'b0;
            started_q   <= 1'b0;
            config_q    <= CTRL_WORD;
            pair_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_d_q     <= irq_d_d;
            hold_a_q    <= hold_a_d;
            hold_b_q    <= hold_b_d;
            hold_full_q <= hold_full_d;
            act_a_q     <= act_a_d;
            ctrl_pend_q <= ctrl_pend_d;
            started_q   <= started_d;
            config_q    <= config_d;
            pair_done_q <= pair_done_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_dac_tlv5638_seq.sv
// Self-checking bench for dac_tlv5638_seq: directed scenarios plus random
// pairs, each slot compared against a queue of expected slot outcomes.
module tb_dac_tlv5638_seq;
    import dac_tlv5638_pkg::*;

    localparam logic [1:0] REF_SEL = 2'b10;
    localparam int         SPD_I   = 1;

    // ---------------- clock / reset ----------------
    logic        clk_20M = 1'b0;
    logic        rst;
    logic        irq;
    logic        ref_update;
    logic [15:0] config_reg;
    logic        pair_done;
    logic        underrun;
    state_e      dbg_state;

    always #25 clk_20M = ~clk_20M;

    dac_tlv5638_seq_if s_if();

    dac_tlv5638_seq #(.REF_SEL(REF_SEL), .SPD(1'b1)) dut (
        .clk_20M    (clk_20M),
        .rst        (rst),
        .irq        (irq),
        .s_if       (s_if.slave),
        .ref_update (ref_update),
        .config_reg (config_reg),
        .pair_done  (pair_done),
        .underrun   (underrun),
        .dbg_state  (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Expected outcome of each slot: word, pair_done pulses, underrun pulses
    logic [15:0] exp_q[$];
    int          exp_pd_q[$];
    int          exp_ur_q[$];
    logic [15:0] last_exp;

    function automatic logic [15:0] mk(input int r1, input int r0, input int data);
        return 16'(r1 * 32768 + SPD_I * 16384 + r0 * 4096 + data);
    endfunction

    function automatic logic [15:0] ctrl_w();
        return mk(1, 1, int'(REF_SEL));
    endfunction

    task automatic push_slot(input logic [15:0] w, input int pd, input int ur);
        exp_q.push_back(w);
        exp_pd_q.push_back(pd);
        exp_ur_q.push_back(ur);
        last_exp = w;
    endtask

    task automatic push_pair(input logic [11:0] a, input logic [11:0] b);
        push_slot(mk(0, 1, int'(b)), 0, 0);
        push_slot(mk(1, 0, int'(a)), 1, 0);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_pair(input logic [11:0] a, input logic [11:0] b);
        int waited;
        waited = 0;
        @(negedge clk_20M);
        while (s_if.s_ready !== 1'b1 && waited < 40) begin
            @(negedge clk_20M);
            waited++;
        end
        chk("send_ready_timeout", 32'(waited < 40), 32'd1);
        s_if.s_valid  = 1'b1;
        s_if.s_data_a = a;
        s_if.s_data_b = b;
        @(negedge clk_20M);
        s_if.s_valid = 1'b0;
    endtask

    // One 1 us irq frame; with_ref raises ref_update in the edge cycle itself
    task automatic expect_slot(input string tag, input logic with_ref);
        logic [15:0] w, ew;
        int pd_n, ur_n, chg, epd, eur;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_model_empty: observed 0 expected >0", tag);
        end
        if (exp_q.size() != 0) begin
            ew  = exp_q.pop_front();
            epd = exp_pd_q.pop_front();
            eur = exp_ur_q.pop_front();
        end else begin
            ew = 16'h0; epd = 0; eur = 0;
        end
        @(negedge clk_20M);
        irq        = 1'b1;
        ref_update = with_ref;
        @(negedge clk_20M);
        ref_update = 1'b0;
        w    = config_reg;
        pd_n = int'(pair_done);
        ur_n = int'(underrun);
        chg  = 0;
        repeat (9) begin
            @(negedge clk_20M);
            pd_n += int'(pair_done);
            ur_n += int'(underrun);
            if (config_reg !== w) chg++;
        end
        irq = 1'b0;
        repeat (10) begin
            @(negedge clk_20M);
            pd_n += int'(pair_done);
            ur_n += int'(underrun);
            if (config_reg !== w) chg++;
        end
        chk({tag, "_word"}, 32'(w), 32'(ew));
        chk({tag, "_pair_done"}, 32'(pd_n), 32'(epd));
        chk({tag, "_underrun"}, 32'(ur_n), 32'(eur));
        chk({tag, "_stable"}, 32'(chg), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [11:0] ra, rb, na, nb;

    initial begin
        rst          = 1'b1;
        irq          = 1'b0;
        ref_update   = 1'b0;
        s_if.s_valid  = 1'b0;
        s_if.s_data_a = '0;
        s_if.s_data_b = '0;
        last_exp      = ctrl_w();
        repeat (3) @(negedge clk_20M);

        // 1. reset state
        chk("rst_config", 32'(config_reg), 32'h0000D002);
        chk("rst_config_model", 32'(config_reg), 32'(ctrl_w()));
        chk("rst_ready", 32'(s_if.s_ready), 32'd1);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_pair_done", 32'(pair_done), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        rst = 1'b0;
        push_slot(ctrl_w(), 0, 0);
        push_slot(ctrl_w(), 0, 0);
        expect_slot("prestart0", 1'b0);
        expect_slot("prestart1", 1'b0);

        // 2. single directed pair
        push_pair(12'h123, 12'hABC);
        send_pair(12'h123, 12'hABC);
        chk("p1_hold_full", 32'(s_if.s_ready), 32'd0);
        expect_slot("p1_bufb", 1'b0);
        chk("p1_drained", 32'(s_if.s_ready), 32'd1);
        chk("p1_state", 32'(dbg_state), 32'(ST_PAIR_A));
        expect_slot("p1_wra", 1'b0);

        // 3. random back-to-back pairs
        ra = 12'($urandom);
        rb = 12'($urandom);
        push_pair(ra, rb);
        send_pair(ra, rb);
        for (int i = 0; i < 6; i++) begin
            expect_slot("rnd_bufb", 1'b0);
            if (i < 5) begin
                na = 12'($urandom_range(0, 4095));
                nb = 12'($urandom_range(0, 4095));
                push_pair(na, nb);
                send_pair(na, nb);
                chk("rnd_ready_low", 32'(s_if.s_ready), 32'd0);
            end
            expect_slot("rnd_wra", 1'b0);
        end

        // ref_update on an IDLE edge with a pair waiting: pair first, then CTRL
        ra = 12'($urandom);
        rb = 12'($urandom);
        push_slot(mk(0, 1, int'(rb)), 0, 0);
        send_pair(ra, rb);
        expect_slot("edge_ref_bufb", 1'b1);
        push_slot(mk(1, 0, int'(ra)), 1, 0);
        push_slot(ctrl_w(), 0, 0);
        expect_slot("edge_ref_wra", 1'b0);
        expect_slot("edge_ref_ctrl", 1'b0);

        // 4. ref_update during PAIR_A
        ra = 12'($urandom);
        rb = 12'($urandom);
        push_pair(ra, rb);
        send_pair(ra, rb);
        expect_slot("mid_ref_bufb", 1'b0);
        @(negedge clk_20M);
        ref_update = 1'b1;
        @(negedge clk_20M);
        ref_update = 1'b0;
        push_slot(ctrl_w(), 0, 0);
        push_pair(12'h123, 12'hABC);
        send_pair(12'h123, 12'hABC);
        expect_slot("mid_ref_wra", 1'b0);
        expect_slot("mid_ref_ctrl", 1'b0);
        expect_slot("mid_ref_bufb2", 1'b0);
        expect_slot("mid_ref_wra2", 1'b0);

        // 5. starvation repeats the last word with one underrun per edge
        push_slot(last_exp, 0, 1);
        push_slot(last_exp, 0, 1);
        expect_slot("starve0", 1'b0);
        expect_slot("starve1", 1'b0);
        chk("starve_word", 32'(config_reg), 32'h0000C123);

        // 6. reset between BUF_B and WR_A, with another pair waiting in hold
        ra = 12'($urandom);
        rb = 12'($urandom);
        push_slot(mk(0, 1, int'(rb)), 0, 0);
        send_pair(ra, rb);
        expect_slot("rstmid_bufb", 1'b0);
        send_pair(12'($urandom), 12'($urandom));
        @(negedge clk_20M);
        rst = 1'b1;
        @(negedge clk_20M);
        chk("rstmid_config", 32'(config_reg), 32'(ctrl_w()));
        chk("rstmid_ready", 32'(s_if.s_ready), 32'd1);
        chk("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rstmid_pair_done", 32'(pair_done), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_pd_q.delete();
        exp_ur_q.delete();
        push_slot(ctrl_w(), 0, 0);
        expect_slot("rstmid_after", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench can never hang
    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
